// File: rtl/mem_stage_lsu_if.sv
// Data-bus handshake between the memory stage and the data memory.
// req/gnt issue the request; rvalid/rdata return load data.
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage: aligns stores, extends loads, and stalls the pipeline while a
// req/gnt/rvalid data-bus access is in flight.
module mem_stage_lsu (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic [31:0]             ex_alu_o,
  input  logic [31:0]             ex_rs2_data,
  input  logic [4:0]              ex_rd,
  input  logic [2:0]              ex_funct3,
  input  logic                    ex_mem_read,
  input  logic                    ex_mem_write,
  input  logic                    ex_mem2reg,
  input  logic                    ex_regs_write,
  mem_stage_lsu_if.master         dbus,
  output logic [31:0]             me_mem_data,
  output logic [31:0]             me_alu_o,
  output logic [4:0]              me_rd,
  output logic                    me_mem2reg,
  output logic                    me_regs_write,
  output logic                    mem_stall,
  output logic                    mem_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q;
  logic              req_q;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [BEW-1:0]    be_q;
  logic [XLEN-1:0]   mdata_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;

  logic              is_half;
  logic              is_word;
  logic              load_f3_bad;
  logic              store_f3_bad;
  logic              misaligned;
  logic              illegal;
  logic              mem_op;
  logic              start;
  logic [BEW-1:0]    st_be;
  logic [XLEN-1:0]   st_wdata;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [XLEN-1:0]   ld_data;

  // Legality decode of the instruction currently in EX/MEM
  always_comb begin
    is_half      = (ex_funct3[1:0] == 2'b01);
    is_word      = (ex_funct3[1:0] == 2'b10);
    load_f3_bad  = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
    store_f3_bad = ex_funct3[2] || (ex_funct3[1:0] == 2'b11);
    misaligned   = (is_half && ex_alu_o[0]) || (is_word && (ex_alu_o[1:0] != 2'b00));
    illegal      = ex_valid && ((ex_mem_read && ex_mem_write)
                             || (ex_mem_read && load_f3_bad)
                             || (ex_mem_write && store_f3_bad)
                             || ((ex_mem_read || ex_mem_write) && misaligned));
    mem_op       = ex_valid && (ex_mem_read ^ ex_mem_write);
    start        = mem_op && !illegal;
  end

  // Store lane replication and byte enables; loads request the full word
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_rs2_data;
    if (ex_mem_write) begin
      case (ex_funct3[1:0])
        2'b00: begin
          st_be    = BEW'(4'b0001 << ex_alu_o[1:0]);
          st_wdata = {4{ex_rs2_data[7:0]}};
        end
        2'b01: begin
          st_be    = ex_alu_o[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{ex_rs2_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load lane extraction uses the offset and size captured at issue
  always_comb begin
    lane_byte = 8'(dbus.rdata >> {off_q, 3'b000});
    lane_half = 16'(dbus.rdata >> {off_q[1], 4'b0000});
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{lane_byte[7] & ~f3_q[2]}}, lane_byte};
      2'b01:   ld_data = {{16{lane_half[15] & ~f3_q[2]}}, lane_half};
      default: ld_data = dbus.rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      mdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= {ex_alu_o[31:2], 2'b00};
            we_q    <= ex_mem_write;
            wdata_q <= st_wdata;
            be_q    <= st_be;
            off_q   <= ex_alu_o[1:0];
            f3_q    <= ex_funct3;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (dbus.gnt) begin
            req_q   <= 1'b0;
            state_q <= we_q ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (dbus.rvalid) begin
            mdata_q <= ld_data;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // DONE drops the stall for one cycle so the pipeline advances exactly once
  always_comb begin
    mem_stall     = !rst && (((state_q == IDLE) && start) || (state_q == REQ) || (state_q == WAIT));
    mem_err       = !rst && (state_q == IDLE) && illegal;
    me_regs_write = !rst && ex_valid && ex_regs_write && !mem_stall && !illegal;
  end

  assign dbus.req    = req_q;
  assign dbus.we     = we_q;
  assign dbus.addr   = addr_q;
  assign dbus.wdata  = wdata_q;
  assign dbus.be     = be_q;
  assign me_mem_data = mdata_q;
  assign me_alu_o    = ex_alu_o;
  assign me_rd       = ex_rd;
  assign me_mem2reg  = ex_mem2reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: transaction-level model of stall,
// bus traffic and load data, plus directed scenarios pinned with literals.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem2reg, ex_regs_write;
  logic [31:0] ex_alu_o, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [31:0] me_mem_data, me_alu_o;
  logic [4:0]  me_rd;
  logic        me_mem2reg, me_regs_write, mem_stall, mem_err;

  mem_stage_lsu_if bus();

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_o(ex_alu_o), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem2reg(ex_mem2reg), .ex_regs_write(ex_regs_write),
    .dbus(bus),
    .me_mem_data(me_mem_data), .me_alu_o(me_alu_o), .me_rd(me_rd),
    .me_mem2reg(me_mem2reg), .me_regs_write(me_regs_write),
    .mem_stall(mem_stall), .mem_err(mem_err)
  );

  int checks = 0;
  int failures = 0;

  // Model state for the instruction currently presented
  logic        cmp_en = 1'b0;
  logic        cur_ill = 1'b0, cur_legal = 1'b0;
  int          cur_g = 0, cur_n = 0, k = 0;
  logic [31:0] exp_addr, exp_wdata, exp_mdata = 32'h0;
  logic [3:0]  exp_be;
  logic        exp_we;
  int          stall_seen = 0, req_seen = 0;
  logic [31:0] mem [int unsigned];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_illegal(logic v, logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
    int sz = int'(f3) % 4;
    if (!v || !(rd || wr)) return 1'b0;
    if (rd && wr) return 1'b1;
    if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (wr && f3 > 2) return 1'b1;
    if (sz == 1 && a % 2 != 0) return 1'b1;
    if (sz == 2 && a % 4 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(logic wr, logic [2:0] f3, logic [31:0] a);
    if (!wr || f3 == 2) return 4'hF;
    if (f3 == 0) return 4'(1 << (a % 4));
    return (a % 4 >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] rs2);
    if (f3 == 0) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] word, logic [2:0] f3, logic [31:0] a);
    logic [31:0] s = word >> (8 * (a % 4));
    logic [31:0] v;
    case (f3)
      3'd0: begin v = s & 32'hFF;   if (v >= 128)   v = v | 32'hFFFF_FF00; end
      3'd4: v = s & 32'hFF;
      3'd1: begin v = s & 32'hFFFF; if (v >= 32768) v = v | 32'hFFFF_0000; end
      3'd5: v = s & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] mem_read(logic [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  task automatic mem_write(input logic [31:0] wa, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w = mem_read(wa);
    for (int i = 0; i < 4; i++)
      if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    mem[wa] = w;
  endtask

  // Per-cycle comparison against the model
  task automatic check_cycle();
    logic exp_stall = cur_legal && (k < cur_n);
    logic exp_req   = cur_legal && (k >= 1) && (k <= cur_g + 1);
    chk("me_alu_o", me_alu_o, ex_alu_o);
    chk("me_rd", 32'(me_rd), 32'(ex_rd));
    chk("me_mem2reg", 32'(me_mem2reg), 32'(ex_mem2reg));
    chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
    chk("mem_err", 32'(mem_err), 32'(cur_ill));
    chk("me_regs_write", 32'(me_regs_write),
        32'(ex_valid && ex_regs_write && !exp_stall && !cur_ill));
    chk("dbus_req", 32'(bus.req), 32'(exp_req));
    if (exp_req) begin
      chk("dbus_addr", bus.addr, exp_addr);
      chk("dbus_we", 32'(bus.we), 32'(exp_we));
      chk("dbus_be", 32'(bus.be), 32'(exp_be));
      if (exp_we) chk("dbus_wdata", bus.wdata, exp_wdata);
    end
    chk("me_mem_data", me_mem_data, exp_mdata);
    if (mem_stall) stall_seen++;
    if (bus.req) req_seen++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (cmp_en) check_cycle();
    end
  end

  // Presents one instruction and plays the bus side with gnt delay g / rvalid delay r
  task automatic do_op(input logic v, input logic rd, input logic wr, input logic m2r,
                       input logic rw, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rs2, input logic [4:0] rdn, input int g, input int r);
    logic [31:0] word;
    int last;
    @(negedge clk);
    cur_ill   = m_illegal(v, rd, wr, f3, a);
    cur_legal = v && (rd != wr) && !cur_ill;
    cur_g     = g;
    cur_n     = !cur_legal ? 0 : (rd ? g + r + 3 : g + 2);
    last      = cur_n;
    exp_addr  = a & ~32'h3;
    exp_we    = wr;
    exp_be    = m_be(wr, f3, a);
    exp_wdata = m_wdata(f3, rs2);
    word      = (cur_legal && rd) ? mem_read(exp_addr) : 32'h0;
    for (int c = 0; c <= last; c++) begin
      if (c != 0) @(negedge clk);
      ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_mem2reg = m2r;
      ex_regs_write = rw; ex_funct3 = f3; ex_alu_o = a; ex_rs2_data = rs2; ex_rd = rdn;
      k = c;
      bus.gnt = cur_legal && (c == g + 1);
      if (cur_legal && rd && c >= g + 2 && c < last) begin
        bus.rvalid = (c == g + 2 + r);
        bus.rdata  = (c == g + 2 + r) ? word : $urandom;
      end else begin
        bus.rvalid = ($urandom_range(0, 3) == 0);
        bus.rdata  = $urandom;
      end
      if (cur_legal && wr && c == g + 1) mem_write(exp_addr, exp_be, exp_wdata);
      if (cur_legal && rd && c == last) exp_mdata = m_load(word, f3, a);
    end
  endtask

  initial begin
    logic v, rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int kind;

    rst = 1'b1;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_mem2reg = 1'b1;
    ex_regs_write = 1'b1; ex_funct3 = 3'd2; ex_alu_o = 32'h100; ex_rs2_data = 32'h0; ex_rd = 5'd1;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req", 32'(bus.req), 32'h0);
    chk("rst_we", 32'(bus.we), 32'h0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    chk("rst_be", 32'(bus.be), 32'h0);
    chk("rst_mem_data", me_mem_data, 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_regs_write", 32'(me_regs_write), 32'h0);

    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    cur_ill = 1'b0; cur_legal = 1'b0; k = 0; exp_mdata = 32'h0;
    cmp_en = 1'b1;

    // ALU op passes through
    req_seen = 0;
    do_op(1, 0, 0, 0, 1, 3'd0, 32'h1234, 32'h0, 5'd5, 0, 0);
    #3;
    chk("alu_regs_write", 32'(me_regs_write), 32'h1);
    chk("alu_alu_o", me_alu_o, 32'h1234);
    chk("alu_stall", 32'(mem_stall), 32'h0);
    chk("alu_no_req", req_seen, 0);

    // LB / LBU at byte 3
    mem[32'h1000] = 32'h80FF_FF7F;
    stall_seen = 0;
    do_op(1, 1, 0, 1, 1, 3'd0, 32'h1003, 32'h0, 5'd7, 0, 0);
    #3;
    chk("lb_data", me_mem_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", stall_seen, 3);
    do_op(1, 1, 0, 1, 1, 3'd4, 32'h1003, 32'h0, 5'd7, 0, 0);
    #3;
    chk("lbu_data", me_mem_data, 32'h0000_0080);

    // SH with grant withheld two cycles
    stall_seen = 0;
    do_op(1, 0, 1, 0, 0, 3'd1, 32'h2002, 32'hDEAD_BEEF, 5'd0, 2, 0);
    #3;
    chk("sh_addr", bus.addr, 32'h2000);
    chk("sh_be", 32'(bus.be), 32'hC);
    chk("sh_wdata", bus.wdata, 32'hBEEF_BEEF);
    chk("sh_we", 32'(bus.we), 32'h1);
    chk("sh_stall_cycles", stall_seen, 4);

    // Misaligned LW
    do_op(1, 1, 0, 1, 1, 3'd2, 32'h3001, 32'h0, 5'd9, 0, 0);
    #3;
    chk("lw_mis_err", 32'(mem_err), 32'h1);
    chk("lw_mis_regs_write", 32'(me_regs_write), 32'h0);
    chk("lw_mis_req", 32'(bus.req), 32'h0);
    chk("lw_mis_stall", 32'(mem_stall), 32'h0);

    // SW then LW back-to-back at the same address
    req_seen = 0;
    do_op(1, 0, 1, 0, 0, 3'd2, 32'h5000, 32'hCAFE_F00D, 5'd0, 0, 0);
    do_op(1, 1, 0, 1, 1, 3'd2, 32'h5000, 32'h0, 5'd3, 0, 0);
    #3;
    chk("b2b_load_data", me_mem_data, 32'hCAFE_F00D);
    chk("b2b_req_cycles", req_seen, 2);

    // Reset while waiting for rvalid, then a stray rvalid
    cmp_en = 1'b0;
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'd2;
    ex_alu_o = 32'h6000; ex_regs_write = 1'b1; ex_mem2reg = 1'b1;
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    @(negedge clk); bus.gnt = 1'b1;
    @(negedge clk); bus.gnt = 1'b0;
    #2;
    chk("wait_stall", 32'(mem_stall), 32'h1);
    chk("wait_req", 32'(bus.req), 32'h0);
    @(negedge clk); rst = 1'b1;
    #2;
    chk("rstw_stall", 32'(mem_stall), 32'h0);
    chk("rstw_regs_write", 32'(me_regs_write), 32'h0);
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h5555_5555;
    #2;
    chk("rstw_req", 32'(bus.req), 32'h0);
    chk("rstw_mem_data", me_mem_data, 32'h0);
    chk("rstw_stall_idle", 32'(mem_stall), 32'h0);
    @(negedge clk);
    bus.rvalid = 1'b0;
    cur_ill = 1'b0; cur_legal = 1'b0; k = 0; exp_mdata = 32'h0;
    cmp_en = 1'b1;
    #2;
    chk("stray_rvalid_data", me_mem_data, 32'h0);
    chk("stray_rvalid_stall", 32'(mem_stall), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      v = 1'b1; rd = 1'b0; wr = 1'b0;
      case (kind)
        0, 1:    ;
        2, 3, 4: rd = 1'b1;
        5, 6, 7: wr = 1'b1;
        8:       begin rd = 1'b1; wr = 1'b1; end
        default: begin v = 1'b0; rd = 1'($urandom); wr = 1'($urandom); end
      endcase
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (rd && !wr) begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
        end else if (wr && !rd) begin
          f3 = 3'($urandom_range(0, 2));
        end
      end
      a = 32'h4000 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a = a & ~32'h1;
        if (f3[1:0] == 2'b10) a = a & ~32'h3;
      end
      do_op(v, rd, wr, 1'($urandom), 1'($urandom), f3, a, $urandom, 5'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
